cp0_reg: RTL

- Coprocessor-0 register file; the consumer end of the write-back CP0 port (`wb_cp0_reg_we/addr/data`).
- Holds Count, Compare, Status, Cause, EPC, PRId and Config.
- Generates the timer interrupt and applies exception entry/return updates from the MEM-stage exception decision.
- Provides one asynchronous read port to EX for mfc0.

---
 rtl/cp0_reg_pkg.sv | 51 +++++
 rtl/cp0_timer.sv | 55 +++++
 rtl/cp0_reg.sv | 102 ++++++++++
 3 files changed

// File: rtl/cp0_reg_pkg.sv
// Shared CP0 constants: register addresses, exception type encodings and ExcCode values.
// Optional build macro CP0_COUNT_HALF_EN (see cp0_timer) halves the Count rate.
package cp0_reg_pkg;

  localparam logic [4:0] CP0_REG_COUNT   = 5'd9;
  localparam logic [4:0] CP0_REG_COMPARE = 5'd11;
  localparam logic [4:0] CP0_REG_STATUS  = 5'd12;
  localparam logic [4:0] CP0_REG_CAUSE   = 5'd13;
  localparam logic [4:0] CP0_REG_EPC     = 5'd14;
  localparam logic [4:0] CP0_REG_PRID    = 5'd15;
  localparam logic [4:0] CP0_REG_CONFIG  = 5'd16;

  localparam logic [31:0] EXC_INT  = 32'h0000_0001;
  localparam logic [31:0] EXC_SYS  = 32'h0000_0008;
  localparam logic [31:0] EXC_RI   = 32'h0000_000a;
  localparam logic [31:0] EXC_OV   = 32'h0000_000c;
  localparam logic [31:0] EXC_TR   = 32'h0000_000d;
  localparam logic [31:0] EXC_ERET = 32'h0000_000e;

  localparam logic [4:0] EXCCODE_INT = 5'h00;
  localparam logic [4:0] EXCCODE_SYS = 5'h08;
  localparam logic [4:0] EXCCODE_RI  = 5'h0a;
  localparam logic [4:0] EXCCODE_OV  = 5'h0c;
  localparam logic [4:0] EXCCODE_TR  = 5'h0d;

  localparam logic [31:0] STATUS_RESET = 32'h1000_0000;
  localparam int          STATUS_EXL   = 1;
  localparam int          CAUSE_BD     = 31;

  typedef struct packed {
    logic       entry;
    logic [4:0] code;
  } exc_decode_t;

  // Maps an exception type to "is this an entry" plus its ExcCode; eret is not an entry.
  function automatic exc_decode_t decode_exc(input logic [31:0] exc_type);
    exc_decode_t d;
    d.entry = 1'b0;
    d.code  = 5'd0;
    case (exc_type)
      EXC_INT: begin d.entry = 1'b1; d.code = EXCCODE_INT; end
      EXC_SYS: begin d.entry = 1'b1; d.code = EXCCODE_SYS; end
      EXC_RI:  begin d.entry = 1'b1; d.code = EXCCODE_RI;  end
      EXC_OV:  begin d.entry = 1'b1; d.code = EXCCODE_OV;  end
      EXC_TR:  begin d.entry = 1'b1; d.code = EXCCODE_TR;  end
      default: ;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/cp0_timer.sv
// Count/Compare timer with sticky interrupt. With CP0_COUNT_HALF_EN defined,
// Count advances only every second cycle; the compare logic is the same in both builds.
module cp0_timer (
  input  logic        clk,
  input  logic        rst,
  input  logic        count_we,
  input  logic        compare_we,
  input  logic [31:0] data,
  output logic [31:0] count,
  output logic [31:0] compare,
  output logic        timer_int
);

  logic advance;

`ifdef CP0_COUNT_HALF_EN
  logic toggle;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      toggle <= 1'b0;
    end else if (count_we) begin
      toggle <= 1'b0;
    end else begin
      toggle <= ~toggle;
    end
  end

  assign advance = toggle;
`else
  assign advance = 1'b1;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count     <= 32'd0;
      compare   <= 32'd0;
      timer_int <= 1'b0;
    end else begin
      if (count_we) begin
        count <= data;
      end else if (advance) begin
        count <= count + 32'd1;
      end
      // A Compare write wins over a match seen in the same cycle.
      if (compare_we) begin
        compare   <= data;
        timer_int <= 1'b0;
      end else if ((compare != 32'd0) && (count == compare)) begin
        timer_int <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/cp0_reg.sv
// CP0 register file: Count/Compare (via cp0_timer), Status, Cause, EPC, PRId, Config,
// exception entry/eret updates and a combinational mfc0 read port. Honours CP0_COUNT_HALF_EN.
module cp0_reg
  import cp0_reg_pkg::*;
#(
  parameter logic [31:0] PRID_VALUE   = 32'h004c_0102,
  parameter logic [31:0] CONFIG_VALUE = 32'h0000_8000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        we_i,
  input  logic [4:0]  waddr_i,
  input  logic [31:0] data_i,
  input  logic [4:0]  raddr_i,
  output logic [31:0] data_o,
  input  logic [5:0]  int_i,
  input  logic [31:0] excepttype_i,
  input  logic [31:0] current_inst_addr_i,
  input  logic        is_in_delayslot_i,
  output logic [31:0] count_o,
  output logic [31:0] compare_o,
  output logic [31:0] status_o,
  output logic [31:0] cause_o,
  output logic [31:0] epc_o,
  output logic [31:0] config_o,
  output logic [31:0] prid_o,
  output logic        timer_int_o
);

  logic        count_we;
  logic        compare_we;
  exc_decode_t exc_dec;
  logic        is_eret;

  assign count_we   = we_i && (waddr_i == CP0_REG_COUNT);
  assign compare_we = we_i && (waddr_i == CP0_REG_COMPARE);
  assign exc_dec    = decode_exc(excepttype_i);
  assign is_eret    = (excepttype_i == EXC_ERET);

  cp0_timer u_timer (
    .clk        (clk),
    .rst        (rst),
    .count_we   (count_we),
    .compare_we (compare_we),
    .data       (data_i),
    .count      (count_o),
    .compare    (compare_o),
    .timer_int  (timer_int_o)
  );

  assign config_o = CONFIG_VALUE;
  assign prid_o   = PRID_VALUE;

  // Software write first; the exception/eret assignments below override the fields they touch.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      status_o <= STATUS_RESET;
      cause_o  <= 32'd0;
      epc_o    <= 32'd0;
    end else begin
      cause_o[15:10] <= int_i;
      if (we_i) begin
        case (waddr_i)
          CP0_REG_STATUS: status_o <= data_i;
          CP0_REG_CAUSE: begin
            cause_o[9:8]   <= data_i[9:8];
            cause_o[23:22] <= data_i[23:22];
          end
          CP0_REG_EPC:    epc_o <= data_i;
          default: ;
        endcase
      end
      if (exc_dec.entry) begin
        // Nested entry (EXL already set) keeps the original return address.
        if (!status_o[STATUS_EXL]) begin
          epc_o             <= is_in_delayslot_i ? (current_inst_addr_i - 32'd4)
                                                 : current_inst_addr_i;
          cause_o[CAUSE_BD] <= is_in_delayslot_i;
        end
        status_o[STATUS_EXL] <= 1'b1;
        cause_o[6:2]         <= exc_dec.code;
      end else if (is_eret) begin
        status_o[STATUS_EXL] <= 1'b0;
      end
    end
  end

  always_comb begin
    data_o = 32'd0;
    case (raddr_i)
      CP0_REG_COUNT:   data_o = count_o;
      CP0_REG_COMPARE: data_o = compare_o;
      CP0_REG_STATUS:  data_o = status_o;
      CP0_REG_CAUSE:   data_o = cause_o;
      CP0_REG_EPC:     data_o = epc_o;
      CP0_REG_PRID:    data_o = PRID_VALUE;
      CP0_REG_CONFIG:  data_o = CONFIG_VALUE;
      default:         data_o = 32'd0;
    endcase
  end

endmodule
